alu_operand_stage: RTL
======================

# alu_operand_stage

Parametrised operand-select pipeline stage between register-file read and the ALU. Accepts one decoded operation per cycle under a valid/ready handshake and selects/extends the B operand. Optionally forwards write-back data onto both operands. Registers the ALU operands behind a 2-entry skid buffer, so back-pressure from the ALU never creates a combinational ready path upstream.

## Interface
- DATA_W, 16, operand width
- IMM_W, 8, immediate width (IMM_W ≤ DATA_W)
- REG_AW, 3, register-address width
- clk  input  1  clock, all state on rising edge
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  upstream operation valid
- in_ready  output  1  stage can accept
- rd_q  input  DATA_W  destination-register read data → A operand
- rs_q  input  DATA_W  source-register read data
- offset  input  IMM_W  immediate
- b_sel  input  2  B select: 00 zero-ext imm, 01 sign-ext imm, 10 rs_q, 11 constant 0
- rd_addr, rs_addr  input  REG_AW each  register addresses, used for forwarding
- wb_en  input  1  write-back strobe
- wb_addr  input  REG_AW  write-back address
- wb_data  input  DATA_W  write-back data
- out_valid  output  1  alu_a/alu_b valid
- out_ready  input  1  ALU accepts
- alu_a, alu_b  output  DATA_W each  registered operands

## Operation
- Accept = in_valid & in_ready; Consume = out_valid & out_ready.
- On accept: A = rd_q; B = mux(b_sel): {0, offset}, {sign(offset[IMM_W-1]), offset}, rs_q, or 0.
- Storage: output register (OR) drives outputs; skid register (SK) holds one overflow entry.
- Accept with OR empty, or OR being consumed and SK empty → entry loads OR.
- Accept with OR full and not consumed → entry loads SK.
- Consume with SK full → SK moves to OR; SK empties.
- in_ready = SK empty (registered). No accept occurs while SK is full.
- Order is strictly FIFO; no entry is dropped or duplicated.
- Throughput: one operation per cycle while out_ready is held high.
- Held entries (OR/SK) are never re-forwarded. Upstream must stall hazards that fall outside the capture cycle.

## Timing
- Reset values: alu_a = 0, alu_b = 0, out_valid = 0, in_ready = 0 while rst is high; in_ready = 1 on the first clock after rst deasserts. SK is empty.
- Latency: accept in cycle N → out_valid with data in cycle N+1.
- out_valid/alu_a/alu_b are held stable while out_valid & !out_ready.
- Simultaneous accept and consume with SK empty: the new entry replaces OR; out_valid stays 1.
- rst asserted mid-operation: both entries are discarded immediately and asynchronously; outputs return to reset values.

## Configuration
- ALU_OPERAND_FWD_EN defined: on accept, if wb_en & wb_addr == rd_addr, A = wb_data.
- Same for rs_addr with b_sel == 10: B = wb_data. Immediate and constant selects are unaffected.
- Forwarding applies only in the capture cycle.
- Not defined: wb_* and the address inputs are ignored; operands come from rd_q/rs_q only.

## Structure
- Package alu_operand_pkg: b_sel encodings (BSEL_IMM_Z, BSEL_IMM_S, BSEL_RS, BSEL_ZERO) and the operand-entry struct (a, b).
- One sub-module: alu_skid_buf, a 2-entry valid/ready register slice parametrised on entry width. The operand-select/forward logic stays in the top.

## Test plan
- Reset: rst=1 mid-stream with two entries held → out_valid=0, alu_a=alu_b=0, in_ready=0; after release, in_ready=1 next cycle.
- Select: rd_q=0x1234, offset=0x80; b_sel 00/01/10 (rs_q=0xBEEF)/11 → alu_b = 0x0080/0xFF80/0xBEEF/0x0000, alu_a = 0x1234, one cycle after accept.
- Back-pressure: stream 4 ops with out_ready=0 → 2 accepted, in_ready=0 from the cycle after the second; release out_ready → outputs in order, no loss.
- Throughput: out_ready=1, in_valid=1 for 8 cycles → 8 outputs on consecutive cycles.
- Forwarding (macro on): rd_addr=3, wb_en=1, wb_addr=3, wb_data=0x00AA, rd_q=0x5555 → alu_a=0x00AA. Macro off → alu_a=0x5555.

Source files
------------

// File: rtl/alu_operand_pkg.sv
// Shared definitions for the ALU operand-select stage: B-operand select
// encodings and the default-width operand entry.
package alu_operand_pkg;

    localparam int ALU_DATA_W = 16;

    typedef enum logic [1:0] {
        BSEL_IMM_Z = 2'b00,   // zero-extended immediate
        BSEL_IMM_S = 2'b01,   // sign-extended immediate
        BSEL_RS    = 2'b10,   // source-register read data
        BSEL_ZERO  = 2'b11    // constant zero
    } bsel_e;

    // Operand pair as presented to the ALU at the default data width.
    typedef struct packed {
        logic [ALU_DATA_W-1:0] a;
        logic [ALU_DATA_W-1:0] b;
    } operand_t;

endpackage

// File: rtl/alu_skid_buf.sv
// Two-entry valid/ready register slice. The output register drives the
// consumer; a skid register absorbs the one entry that can arrive while the
// output is stalled. Upstream ready is purely registered, so consumer
// back-pressure never reaches upstream combinationally.
module alu_skid_buf #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] in_data_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] out_data_o
);

    logic             or_valid_q, or_valid_d;
    logic [WIDTH-1:0] or_data_q,  or_data_d;
    logic             sk_valid_q, sk_valid_d;
    logic [WIDTH-1:0] sk_data_q,  sk_data_d;
    logic             ready_q;
    logic             accept;
    logic             consume;

    assign accept  = in_valid_i & ready_q;
    assign consume = or_valid_q & out_ready_i;

    // Next-state for the two entries; ready_q is low whenever SK is full,
    // so an accept never coincides with a full skid register.
    always_comb begin
        or_valid_d = or_valid_q;
        or_data_d  = or_data_q;
        sk_valid_d = sk_valid_q;
        sk_data_d  = sk_data_q;
        if (sk_valid_q) begin
            if (consume) begin
                or_data_d  = sk_data_q;
                sk_valid_d = 1'b0;
            end
        end else if (accept) begin
            if (!or_valid_q || consume) begin
                or_data_d  = in_data_i;
                or_valid_d = 1'b1;
            end else begin
                sk_data_d  = in_data_i;
                sk_valid_d = 1'b1;
            end
        end else if (consume) begin
            or_valid_d = 1'b0;
        end
    end

    // Entry and ready registers; reset discards both entries immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            or_valid_q <= 1'b0;
            or_data_q  <= '0;
            sk_valid_q <= 1'b0;
            sk_data_q  <= '0;
            ready_q    <= 1'b0;
        end else begin
            or_valid_q <= or_valid_d;
            or_data_q  <= or_data_d;
            sk_valid_q <= sk_valid_d;
            sk_data_q  <= sk_data_d;
            ready_q    <= !sk_valid_d;
        end
    end

    assign in_ready_o  = ready_q;
    assign out_valid_o = or_valid_q;
    assign out_data_o  = or_data_q;

endmodule

// File: rtl/alu_operand_stage.sv
// Operand-select stage between register-file read and the ALU. Selects and
// extends the B operand, optionally forwards write-back data in the capture
// cycle, and registers the operand pair behind a 2-entry skid buffer.
// Optional feature macro: ALU_OPERAND_FWD_EN (write-back forwarding).
module alu_operand_stage
    import alu_operand_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int IMM_W  = 8,
    parameter int REG_AW = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] rd_q,
    input  logic [DATA_W-1:0] rs_q,
    input  logic [IMM_W-1:0]  offset,
    input  logic [1:0]        b_sel,
    input  logic [REG_AW-1:0] rd_addr,
    input  logic [REG_AW-1:0] rs_addr,
    input  logic              wb_en,
    input  logic [REG_AW-1:0] wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b
);

    typedef struct packed {
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
    } entry_t;

    entry_t            in_entry;
    entry_t            out_entry;
    logic [DATA_W-1:0] rs_val;
    logic [DATA_W-1:0] rd_val;

`ifdef ALU_OPERAND_FWD_EN
    // Write-back bypass; only affects the entry being captured this cycle.
    always_comb begin
        rd_val = rd_q;
        rs_val = rs_q;
        if (wb_en && (wb_addr == rd_addr)) rd_val = wb_data;
        if (wb_en && (wb_addr == rs_addr)) rs_val = wb_data;
    end
`else
    logic unused_fwd;
    assign unused_fwd = ^{wb_en, wb_addr, wb_data, rd_addr, rs_addr};

    // Without forwarding the operands come straight from the register file.
    always_comb begin
        rd_val = rd_q;
        rs_val = rs_q;
    end
`endif

    // B-operand select and extension.
    always_comb begin
        in_entry.a = rd_val;
        in_entry.b = '0;
        case (bsel_e'(b_sel))
            BSEL_IMM_Z: in_entry.b = DATA_W'(offset);
            BSEL_IMM_S: in_entry.b = DATA_W'($signed(offset));
            BSEL_RS:    in_entry.b = rs_val;
            BSEL_ZERO:  in_entry.b = '0;
            default:    in_entry.b = '0;
        endcase
    end

    alu_skid_buf #(
        .WIDTH (2*DATA_W)
    ) u_skid (
        .clk         (clk),
        .rst         (rst),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .in_data_i   (in_entry),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .out_data_o  (out_entry)
    );

    assign alu_a = out_entry.a;
    assign alu_b = out_entry.b;

endmodule
